// File: rtl/cache_mem_bridge.sv
// Line-transfer engine between the L1 cache and a 32-bit memory bus: write-back serialiser and refill assembler.
// Optional per-beat ack timeout enabled by defining CACHE_BRIDGE_TIMEOUT_EN.
module cache_mem_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LINE_BYTES     = 16,
    parameter int unsigned BEAT_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_req,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [LINE_BYTES*8-1:0] wb_line,
    output logic                    wb_done,
    input  logic                    fill_req,
    input  logic [ADDR_W-1:0]       fill_addr,
    output logic [LINE_BYTES*8-1:0] fill_line,
    output logic                    fill_done,
    output logic                    busy,
    output logic                    err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [BEAT_BYTES*8-1:0] mem_wdata,
    input  logic [BEAT_BYTES*8-1:0] mem_rdata,
    input  logic                    mem_ack
);
    localparam int unsigned BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int unsigned BEAT_W = BEAT_BYTES * 8;
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned K_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SH_W   = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 0;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    if ((LINE_BYTES % BEAT_BYTES) != 0 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 256) begin : g_param_check
        $error("cache_mem_bridge: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base;
    logic [LINE_W-1:0]   line_q;
    logic [K_W-1:0]      k;
    logic                op_wb;
    logic                last_beat;
    logic                xfer;
    logic                timed_out;

    assign xfer      = (state == S_WB) || (state == S_FILL);
    assign last_beat = (k == K_W'(BEATS - 1));

`ifdef CACHE_BRIDGE_TIMEOUT_EN
    logic [7:0] wcnt;
    logic       err_q;

    assign timed_out = xfer && !mem_ack && (wcnt == 8'(TIMEOUT_CYCLES - 1));
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            err_q <= 1'b0;
        end else if (state == S_IDLE) begin
            if (wb_req || fill_req) begin
                wcnt  <= '0;
                err_q <= 1'b0;
            end
        end else if (xfer) begin
            if (mem_ack)        wcnt  <= '0;
            else                wcnt  <= wcnt + 8'd1;
            if (timed_out)      err_q <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            base      <= '0;
            line_q    <= '0;
            k         <= '0;
            op_wb     <= 1'b0;
            fill_line <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                // Write-back has priority; the pending fill is taken on a later IDLE pass.
                if (wb_req) begin
                    base   <= wb_addr & LINE_MASK;
                    line_q <= wb_line;
                    op_wb  <= 1'b1;
                    k      <= '0;
                end else if (fill_req) begin
                    base   <= fill_addr & LINE_MASK;
                    op_wb  <= 1'b0;
                    k      <= '0;
                end
            end else if (xfer && mem_ack) begin
                k <= k + K_W'(1);
                if (state == S_FILL) fill_line[k*BEAT_W +: BEAT_W] <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wb_req)        state_nxt = S_WB;
                else if (fill_req) state_nxt = S_FILL;
            end
            S_WB, S_FILL: begin
                if ((mem_ack && last_beat) || timed_out) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign mem_req   = xfer;
    assign mem_we    = (state == S_WB);
    assign mem_addr  = base + (ADDR_W'(k) << SH_W);
    assign mem_wdata = line_q[k*BEAT_W +: BEAT_W];
    assign wb_done   = (state == S_DONE) && op_wb;
    assign fill_done = (state == S_DONE) && !op_wb;

endmodule
